// File: rtl/mem_init_loader_pkg.sv
// Shared definitions for the memory init loader: FSM encoding and depth helper.
package mem_init_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  // Byte address width in, word count out (one word per 4 byte addresses).
  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << (addr_width - 2);
  endfunction

endpackage

// File: rtl/mem_init_checksum.sv
// Modular (wrap-around) accumulator with synchronous clear and enable.
module mem_init_checksum #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] data,
  output logic [W-1:0] sum,
  output logic [W-1:0] sum_next
);

  logic [W-1:0] sum_q;
  logic [W-1:0] sum_d;

  always_comb begin
    sum_next = sum_q + data;
    sum_d    = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (en) begin
      sum_d = sum_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/mem_init_loader.sv
// Streams words into memory from address 0, optionally verifies by read-back
// checksum, then hands the memory to the user side via sel.
module mem_init_loader
  import mem_init_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int VERIFY     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  wr_enable_init,
  output logic                  rd_enable_init,
  output logic                  wclk_init,
  output logic                  rclk_init,
  output logic [ADDR_WIDTH-3:0] waddr_init,
  output logic [ADDR_WIDTH-3:0] raddr_init,
  output logic [DATA_WIDTH-1:0] mem_data_in_init,
  input  logic [DATA_WIDTH-1:0] mem_data_out_init,
  output logic                  sel,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-2:0] word_count,
  output state_e                state_dbg
);

  localparam int WA    = ADDR_WIDTH - 2;
  localparam int CW    = ADDR_WIDTH - 1;
  localparam int DEPTH = int'(depth_of(ADDR_WIDTH));
  localparam logic [WA-1:0] LAST_ADDR = WA'(DEPTH - 1);

  // Stream handshake: a word transfers in a cycle where in_valid and
  // in_ready are both high; in_ready does not depend on in_valid.
  state_e                state_q,     state_d;
  logic [WA-1:0]         addr_q,      addr_d;
  logic [CW-1:0]         count_q,     count_d;
  logic                  wr_en_q,     wr_en_d;
  logic [WA-1:0]         wr_addr_q,   wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q,   wr_data_d;
  logic [WA-1:0]         raddr_q,     raddr_d;
  logic                  rd_valid_q,  rd_valid_d;

  logic                  accept;
  logic                  restart;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] wsum;
  logic [DATA_WIDTH-1:0] rsum;
  logic [DATA_WIDTH-1:0] wsum_next;
  logic [DATA_WIDTH-1:0] rsum_next;

  always_comb begin
    in_ready   = (state_q == ST_LOAD);
    accept     = in_valid & in_ready;
    restart    = start & ((state_q == ST_IDLE) | (state_q == ST_DONE) |
                          (state_q == ST_ERROR));
    // Hold off the first read while the final write is still on the port.
    rd_en      = (state_q == ST_VERIFY) & ~wr_en_q;

    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    raddr_d    = raddr_q;
    wr_en_d    = accept;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_valid_d = rd_en;

    if (accept) begin
      wr_addr_d = addr_q;
      wr_data_d = in_data;
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (restart) begin
          state_d = ST_LOAD;
          addr_d  = '0;
          count_d = '0;
          raddr_d = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          addr_d  = addr_q + WA'(1);
          count_d = count_q + CW'(1);
          if (addr_q == LAST_ADDR) begin
            state_d = (VERIFY != 0) ? ST_VERIFY : ST_DONE;
          end
        end
      end
      ST_VERIFY: begin
        if (rd_en) begin
          raddr_d = raddr_q + WA'(1);
          if (raddr_q == LAST_ADDR) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        // rsum_next folds in the last read word arriving this cycle.
        state_d = (rsum_next == wsum) ? ST_DONE : ST_ERROR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      raddr_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      raddr_q    <= raddr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  mem_init_checksum #(.W(DATA_WIDTH)) u_wsum (
    .clk      (clk),
    .rst      (reset),
    .clr      (restart),
    .en       (accept),
    .data     (in_data),
    .sum      (wsum),
    .sum_next (wsum_next)
  );

  mem_init_checksum #(.W(DATA_WIDTH)) u_rsum (
    .clk      (clk),
    .rst      (reset),
    .clr      (restart),
    .en       (rd_valid_q),
    .data     (mem_data_out_init),
    .sum      (rsum),
    .sum_next (rsum_next)
  );

  logic unused_wsum_next;
  assign unused_wsum_next = ^wsum_next;

  assign wclk_init        = clk;
  assign rclk_init        = clk;
  assign wr_enable_init   = wr_en_q;
  assign waddr_init       = wr_addr_q;
  assign mem_data_in_init = wr_data_q;
  assign rd_enable_init   = rd_en;
  assign raddr_init       = raddr_q;
  assign word_count       = count_q;
  assign sel              = (state_q == ST_DONE);
  assign done             = (state_q == ST_DONE);
  assign error            = (state_q == ST_ERROR);
  assign busy             = (state_q == ST_LOAD) | (state_q == ST_VERIFY) |
                            (state_q == ST_CHECK);
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_mem_init_loader.sv
// Bench for mem_init_loader at DEPTH=4: verify and no-verify builds, sync RAM models.
module tb_mem_init_loader;
  import mem_init_loader_pkg::*;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // ---------------- DUT with VERIFY=1 ----------------
  logic       start = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, wr_enable_init, rd_enable_init, wclk_init, rclk_init;
  logic [1:0] waddr_init, raddr_init;
  logic [7:0] mem_data_in_init, mem_data_out_init;
  logic       sel, busy, done, error;
  logic [2:0] word_count;
  state_e     state_dbg;

  mem_init_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .VERIFY(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .wr_enable_init(wr_enable_init),
    .rd_enable_init(rd_enable_init), .wclk_init(wclk_init), .rclk_init(rclk_init),
    .waddr_init(waddr_init), .raddr_init(raddr_init),
    .mem_data_in_init(mem_data_in_init), .mem_data_out_init(mem_data_out_init),
    .sel(sel), .busy(busy), .done(done), .error(error),
    .word_count(word_count), .state_dbg(state_dbg)
  );

  // ---------------- DUT with VERIFY=0 ----------------
  logic       start0 = 1'b0, in_valid0 = 1'b0;
  logic [7:0] in_data0 = '0;
  logic       in_ready0, wr_en0, rd_en0, wclk0, rclk0;
  logic [1:0] waddr0, raddr0;
  logic [7:0] wdata0, rdata0;
  logic       sel0, busy0, done0, error0;
  logic [2:0] word_count0;
  state_e     state_dbg0;

  mem_init_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .VERIFY(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .in_valid(in_valid0),
    .in_data(in_data0), .in_ready(in_ready0), .wr_enable_init(wr_en0),
    .rd_enable_init(rd_en0), .wclk_init(wclk0), .rclk_init(rclk0),
    .waddr_init(waddr0), .raddr_init(raddr0),
    .mem_data_in_init(wdata0), .mem_data_out_init(rdata0),
    .sel(sel0), .busy(busy0), .done(done0), .error(error0),
    .word_count(word_count0), .state_dbg(state_dbg0)
  );

  // ---------------- RAM models ----------------
  logic [7:0] ram1 [4];
  logic [7:0] ram0 [4];
  logic       corrupt = 1'b0;
  logic       rd0_seen = 1'b0;

  always @(posedge clk) begin
    if (wr_enable_init)
      ram1[waddr_init] <= (corrupt && waddr_init == 2'd2) ? 8'h34 : mem_data_in_init;
    if (rd_enable_init) mem_data_out_init <= ram1[raddr_init];
    if (wr_en0) ram0[waddr0] <= wdata0;
    if (rd_en0) rdata0 <= ram0[raddr0];
  end

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- write scoreboard ----------------
  logic [9:0] exp_q[$];
  logic [9:0] exp_e;

  always @(negedge clk) begin
    if (!reset) begin
      if (wr_enable_init | rd_enable_init)
        check("enables_exclusive", 32'(wr_enable_init & rd_enable_init), 32'd0);
      if (wr_enable_init) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {22'd0, waddr_init, mem_data_in_init}, 32'h3ff);
        end else begin
          exp_e = exp_q.pop_front();
          check("write_addr_data", {22'd0, waddr_init, mem_data_in_init}, {22'd0, exp_e});
        end
      end
      if (rd_en0) rd0_seen = 1'b1;
    end
  end

  // ---------------- driver tasks (VERIFY=1 DUT) ----------------
  task automatic pulse_start1();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send1(input logic [31:0] words, input int gap, input bit start_mid,
                       input int nwords);
    logic [1:0] a;
    for (int i = 0; i < nwords; i++) begin
      a        = i[1:0];
      in_valid = 1'b1;
      in_data  = words[8*i +: 8];
      if (start_mid && i == 2) start = 1'b1;
      @(negedge clk);
      check("in_ready_load", 32'(in_ready), 32'd1);
      exp_q.push_back({a, in_data});
      @(posedge clk); #1;
      in_valid = 1'b0;
      start    = 1'b0;
      if (i < nwords - 1) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_end1(output int cnt);
    cnt = 0;
    @(negedge clk);
    while (!(done || error) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] words;
    int          gap;
    bit          corrupt;
    bit          start_mid;
    bit          exp_done;
    bit          exp_err;
    int          exp_lat;
    logic [7:0]  exp_wsum;
    logic [7:0]  exp_rsum;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v);
    int lat;
    corrupt = v.corrupt;
    pulse_start1();
    check("state_load", 32'(state_dbg), 32'(ST_LOAD));
    send1(v.words, v.gap, v.start_mid, 4);
    wait_end1(lat);
    check("latency", lat, v.exp_lat);
    check("done", 32'(done), 32'(v.exp_done));
    check("error", 32'(error), 32'(v.exp_err));
    check("sel", 32'(sel), 32'(v.exp_done));
    check("word_count", 32'(word_count), 32'd4);
    check("wsum", 32'(u_dut1.wsum), 32'(v.exp_wsum));
    check("rsum", 32'(u_dut1.rsum), 32'(v.exp_rsum));
    check("enables_idle", {30'd0, wr_enable_init, rd_enable_init}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] em;
      em = v.exp_mem;
      check("ram_contents", 32'(ram1[k]), 32'(em[8*k +: 8]));
    end
    check("writes_drained", exp_q.size(), 32'd0);
    corrupt = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    vecs[0] = '{32'h44332211, 0, 1'b0, 1'b0, 1'b1, 1'b0, 6, 8'hAA, 8'hAA, 32'h44332211};
    vecs[1] = '{32'h44332211, 3, 1'b0, 1'b0, 1'b1, 1'b0, 6, 8'hAA, 8'hAA, 32'h44332211};
    vecs[2] = '{32'h44332211, 0, 1'b1, 1'b0, 1'b0, 1'b1, 6, 8'hAA, 8'hAB, 32'h44342211};
    vecs[3] = '{32'h44332211, 1, 1'b0, 1'b0, 1'b1, 1'b0, 6, 8'hAA, 8'hAA, 32'h44332211};
    vecs[4] = '{32'h04030201, 0, 1'b0, 1'b1, 1'b1, 1'b0, 6, 8'h0A, 8'h0A, 32'h04030201};

    // reset state
    #3;
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_flags", {26'd0, sel, busy, done, error, in_ready, wr_enable_init}, 32'd0);
    check("rst_rd_en", 32'(rd_enable_init), 32'd0);
    check("rst_addr_data", {14'd0, waddr_init, raddr_init, mem_data_in_init, 3'd0, word_count}, 32'd0);
    check("rst_wsum", 32'(u_dut1.wsum), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;

    // table-driven loads (includes corruption, recovery and start during LOAD)
    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    // start in DONE: sel falls the same cycle LOAD is entered
    start = 1'b1;
    @(negedge clk);
    check("sel_before_restart", 32'(sel), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_state", 32'(state_dbg), 32'(ST_LOAD));
    check("restart_sel", 32'(sel), 32'd0);
    check("restart_count", 32'(word_count), 32'd0);
    send1(32'h44332211, 0, 1'b0, 4);
    wait_end1(lat);
    check("restart_done", 32'(done), 32'd1);

    // asynchronous reset after two accepted words
    pulse_start1();
    send1(32'h88776655, 0, 1'b0, 2);
    check("count_before_reset", 32'(word_count), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("arst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("arst_flags", {26'd0, sel, busy, done, error, in_ready, wr_enable_init}, 32'd0);
    check("arst_addr_data", {14'd0, waddr_init, raddr_init, mem_data_in_init, 3'd0, word_count}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    run_vec(vecs[0]);

    // VERIFY=0 build: 0xFF x4, wsum wraps to 0xFC, DONE right after last accept
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid0 = 1'b1;
      in_data0  = 8'hFF;
      @(posedge clk); #1;
    end
    in_valid0 = 1'b0;
    check("v0_done", 32'(done0), 32'd1);
    check("v0_sel", 32'(sel0), 32'd1);
    check("v0_wsum", 32'(u_dut0.wsum), 32'hFC);
    check("v0_count", 32'(word_count0), 32'd4);
    check("v0_in_ready", 32'(in_ready0), 32'd0);
    @(posedge clk); #1;
    check("v0_wr_idle", 32'(wr_en0), 32'd0);
    check("v0_no_reads", 32'(rd0_seen), 32'd0);
    for (int k = 0; k < 4; k++) check("v0_ram", 32'(ram0[k]), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_init_loader.md
Name: mem_init_loader

Overview:
- Upstream init master for the user/init memory port mux; drives its whole init-side port set plus its select line.
- Accepts a word stream over valid/ready and writes it sequentially into memory from word address 0.
- Optionally reads the memory back and compares checksums, then hands the memory to the user side by raising sel.

Parameters:
DATA_WIDTH, 8, memory word width in bits
ADDR_WIDTH, 8, byte address width; word address width is ADDR_WIDTH-2; DEPTH = 2**(ADDR_WIDTH-2) words
VERIFY, 1, 1 = read-back checksum pass after load; 0 = skip verify

Ports:
clk  in  1  single system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR
in_valid  in  1  stream word valid
in_data  in  DATA_WIDTH  stream word
in_ready  out  1  loader accepts a word this cycle
wr_enable_init  out  1  memory write enable, init side
rd_enable_init  out  1  memory read enable, init side
wclk_init  out  1  equals clk
rclk_init  out  1  equals clk
waddr_init  out  ADDR_WIDTH-2  write word address
raddr_init  out  ADDR_WIDTH-2  read word address
mem_data_in_init  out  DATA_WIDTH  write data
mem_data_out_init  in  DATA_WIDTH  read data; valid one cycle after rd_enable_init
sel  out  1  0 = init owns memory, 1 = user owns memory
busy  out  1  high in LOAD, VERIFY or CHECK
done  out  1  high in DONE
error  out  1  high in ERROR
word_count  out  ADDR_WIDTH-1  words accepted in the current load, 0..DEPTH

Behaviour:
- Reset values: state IDLE; sel, busy, done, error, in_ready, wr_enable_init and rd_enable_init are 0. Addresses, write data, word_count and both checksums are 0.
- Reset mid-operation aborts immediately and returns to reset values. Memory contents are then undefined. sel stays 0 until a complete load finishes.
- IDLE: in_ready = 0. A start pulse moves to LOAD and clears the address, word_count and both checksums.
- LOAD:
  - in_ready = 1 combinationally while in LOAD.
  - On in_valid & in_ready, the next cycle has wr_enable_init = 1, waddr_init = current address, mem_data_in_init = in_data. Write latency is 1 cycle.
  - On each accepted word: wsum += in_data mod 2**DATA_WIDTH, word_count += 1, address += 1.
  - No write is issued in cycles without a handshake.
  - The cycle that accepts word DEPTH-1 leaves LOAD: to VERIFY if VERIFY = 1, otherwise to DONE. in_ready is 0 from the next cycle.
  - Any in_valid beyond DEPTH words is not accepted.
- VERIFY:
  - The first read is issued in the cycle after the last write is presented, so that write is already committed.
  - Issues rd_enable_init = 1 with raddr_init = 0..DEPTH-1, one per cycle, no gaps.
  - Each read's data is captured one cycle later: rsum += mem_data_out_init.
  - After the read of DEPTH-1 is issued, moves to CHECK. CHECK captures the final read data.
- CHECK (1 cycle): compares rsum (including the final word) with wsum. Equal -> DONE; unequal -> ERROR.
- DONE: sel = 1, done = 1, both enables 0.
- ERROR: error = 1, sel = 0.
- start in DONE or ERROR restarts LOAD: sel drops to 0 in the same cycle the state enters LOAD. start in LOAD, VERIFY or CHECK is ignored.
- Verify latency: DEPTH+1 cycles from the first read issue to the DONE/ERROR state.
- wclk_init and rclk_init are combinational copies of clk.
- Enables are never both asserted in the same cycle.

Decomposition:
- Shared package holds the state encoding (IDLE, LOAD, VERIFY, CHECK, DONE, ERROR) and a DEPTH helper function of ADDR_WIDTH.
- One sub-module, mem_init_checksum: a DATA_WIDTH modular accumulator with clear and enable, instantiated twice (wsum, rsum).

Test Plan:
1. ADDR_WIDTH=4 (DEPTH=4), VERIFY=1, ideal sync-RAM model; start, then stream 0x11,0x22,0x33,0x44 back-to-back -> writes at addresses 0..3; wsum = rsum = 0xAA; done = 1 and sel = 1 exactly 6 cycles after the last write cycle.
2. Same stream with in_valid low for 3 cycles between each word -> no writes in the gap cycles; final memory 11,22,33,44; done = 1.
3. RAM model corrupts address 2 to 0x34 -> rsum = 0xAB != 0xAA; error = 1, sel = 0, done = 0; a later start plus a good stream -> done = 1.
4. VERIFY=0, stream 0xFF ×4 -> rd_enable_init never asserted; DONE one cycle after the last accept; wsum = 0xFC wraps without overflow side effects.
5. Assert reset after 2 accepted words -> all outputs return to reset values asynchronously; sel = 0, word_count = 0; a following start reloads from address 0.
6. start pulse during LOAD -> ignored, address continues; start in DONE -> sel drops to 0 in the same cycle the state enters LOAD.
